// File: rtl/bp_be_pkg.sv
// Backend shared types: instruction buffer entry layout and its width helper.
// The declare macro lets a parameterized block build an entry type at its own widths.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_INSTR_BUFFER_ENTRY_WIDTH(vaddr_width_mp, instr_width_mp) \
    ((vaddr_width_mp) + (instr_width_mp))

`define DECLARE_BP_BE_INSTR_BUFFER_ENTRY_S(vaddr_width_mp, instr_width_mp) \
    typedef struct packed {                                                  \
        logic [(vaddr_width_mp)-1:0] pc;                                      \
        logic [(instr_width_mp)-1:0] instr;                                   \
    } bp_be_instr_buffer_entry_s

package bp_be_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;

    `DECLARE_BP_BE_INSTR_BUFFER_ENTRY_S(vaddr_width_gp, instr_width_gp);

endpackage

`endif

// File: rtl/bp_be_instr_buffer_mem.sv
// 1W/1R register file backing the instruction buffer.
// Asynchronous read, synchronous write, storage cleared on reset so reads are never X.
module bp_be_instr_buffer_mem
    import bp_be_pkg::*;
#(
    parameter int els_p   = 8,
    parameter int width_p = `BP_BE_INSTR_BUFFER_ENTRY_WIDTH(vaddr_width_gp, instr_width_gp),
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [els_p-1:0][width_p-1:0] mem_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            mem_r <= '0;
        else if (w_v_i)
            mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_instr_buffer.sv
// Circular FE->decoder instruction buffer; issued entries stay resident until commit
// so a rollback can replay them without refetching.
module bp_be_instr_buffer
    import bp_be_pkg::*;
#(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = vaddr_width_gp,
    parameter int instr_width_p = instr_width_gp,
    localparam int ptr_width_lp = $clog2(els_p) + 1,
    localparam int idx_width_lp = ptr_width_lp - 1,
    localparam int entry_width_lp = `BP_BE_INSTR_BUFFER_ENTRY_WIDTH(vaddr_width_p, instr_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     fe_v_i,
    input  logic [vaddr_width_p-1:0] fe_pc_i,
    input  logic [instr_width_p-1:0] fe_instr_i,
    output logic                     fe_ready_o,

    output logic                     issue_v_o,
    output logic [vaddr_width_p-1:0] issue_pc_o,
    output logic [instr_width_p-1:0] issue_instr_o,
    output logic                     fe_nop_v_o,
    input  logic                     issue_yumi_i,

    input  logic                     commit_v_i,
    input  logic                     roll_v_i,
    input  logic                     flush_v_i
);

    `DECLARE_BP_BE_INSTR_BUFFER_ENTRY_S(vaddr_width_p, instr_width_p);

    // Pointers carry an extra wrap bit so full (occ == els_p) and empty are distinct.
    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] occ, pend, inflight, cptr_next;
    logic                    enq, yumi;

    bp_be_instr_buffer_entry_s wr_entry, rd_entry;

    assign occ      = wptr_r - cptr_r;
    assign pend     = wptr_r - rptr_r;
    assign inflight = rptr_r - cptr_r;

    assign fe_ready_o = (occ != ptr_width_lp'(els_p));
    assign issue_v_o  = (pend != '0);
    assign fe_nop_v_o = ~issue_v_o;

    assign enq       = fe_v_i & fe_ready_o;
    assign yumi      = issue_yumi_i & issue_v_o;
    assign cptr_next = cptr_r + ptr_width_lp'(commit_v_i);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_v_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_r + ptr_width_lp'(enq);
            cptr_r <= cptr_next;
            // Rollback rewinds to the post-commit oldest entry; a same-cycle yumi is dropped.
            rptr_r <= roll_v_i ? cptr_next : rptr_r + ptr_width_lp'(yumi);
        end
    end

    assign wr_entry.pc    = fe_pc_i;
    assign wr_entry.instr = fe_instr_i;

    bp_be_instr_buffer_mem #(
        .els_p   (els_p),
        .width_p (entry_width_lp)
    ) mem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .w_v_i     (enq & ~flush_v_i),
        .w_addr_i  (wptr_r[idx_width_lp-1:0]),
        .w_data_i  (wr_entry),
        .r_addr_i  (rptr_r[idx_width_lp-1:0]),
        .r_data_o  (rd_entry)
    );

    assign issue_pc_o    = rd_entry.pc;
    assign issue_instr_o = rd_entry.instr;

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i || flush_v_i)
        issue_yumi_i |-> issue_v_o)
        else $error("issue_yumi_i while no entry is pending");

    a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i || flush_v_i)
        commit_v_i |-> ((inflight != '0) || issue_yumi_i))
        else $error("commit_v_i with no issued entry");

endmodule

// File: tb/tb_bp_be_instr_buffer.sv
// Randomized + directed bench for bp_be_instr_buffer against a queue-based reference model.
module tb_bp_be_instr_buffer;

    localparam int ELS = 8;
    localparam int VW  = 39;
    localparam int IW  = 32;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          fe_v_i;
    logic [VW-1:0] fe_pc_i;
    logic [IW-1:0] fe_instr_i;
    logic          fe_ready_o;
    logic          issue_v_o;
    logic [VW-1:0] issue_pc_o;
    logic [IW-1:0] issue_instr_o;
    logic          fe_nop_v_o;
    logic          issue_yumi_i;
    logic          commit_v_i;
    logic          roll_v_i;
    logic          flush_v_i;

    always #5 clk = ~clk;

    bp_be_instr_buffer #(.els_p(ELS), .vaddr_width_p(VW), .instr_width_p(IW)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .fe_v_i        (fe_v_i),
        .fe_pc_i       (fe_pc_i),
        .fe_instr_i    (fe_instr_i),
        .fe_ready_o    (fe_ready_o),
        .issue_v_o     (issue_v_o),
        .issue_pc_o    (issue_pc_o),
        .issue_instr_o (issue_instr_o),
        .fe_nop_v_o    (fe_nop_v_o),
        .issue_yumi_i  (issue_yumi_i),
        .commit_v_i    (commit_v_i),
        .roll_v_i      (roll_v_i),
        .flush_v_i     (flush_v_i)
    );

    typedef struct {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;

    // Model: q holds every uncommitted entry oldest-first; the first 'issued' have been issued.
    ent_t q[$];
    int   issued;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("fe_ready", 64'(fe_ready_o), 64'(q.size() != ELS));
        chk("issue_v",  64'(issue_v_o),  64'(issued < q.size()));
        chk("fe_nop",   64'(fe_nop_v_o), 64'(issued >= q.size()));
        if (issued < q.size()) begin
            chk("issue_pc",    64'(issue_pc_o),    64'(q[issued].pc));
            chk("issue_instr", 64'(issue_instr_o), 64'(q[issued].instr));
        end
    endtask

    // One clock: check outputs on the current (post-negedge) state, drive, clock, update model.
    task automatic step(input bit fv, input logic [VW-1:0] pc, input logic [IW-1:0] ins,
                        input bit y, input bit c, input bit r, input bit f, input bit rst = 1'b0);
        bit full;
        check_outputs();
        fe_v_i = fv; fe_pc_i = pc; fe_instr_i = ins;
        issue_yumi_i = y; commit_v_i = c; roll_v_i = r; flush_v_i = f;
        reset_n_i = ~rst;
        full = (q.size() == ELS);
        @(posedge clk);
        if (rst || f) begin
            q.delete();
            issued = 0;
        end else begin
            if (fv && !full) q.push_back('{pc: pc, instr: ins});
            if (!r && y) issued++;
            if (c) begin
                void'(q.pop_front());
                if (issued > 0) issued--;
            end
            if (r) issued = 0;
        end
        @(negedge clk);
        fe_v_i = 1'b0; issue_yumi_i = 1'b0; commit_v_i = 1'b0;
        roll_v_i = 1'b0; flush_v_i = 1'b0; reset_n_i = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [VW-1:0] pc;
        bit fv, y, c, r, f, rst;
        q.delete(); issued = 0;
        fe_v_i = 0; fe_pc_i = '0; fe_instr_i = '0; issue_yumi_i = 0;
        commit_v_i = 0; roll_v_i = 0; flush_v_i = 0; reset_n_i = 0;

        // Reset held two cycles, then idle state
        @(negedge clk); @(negedge clk);
        reset_n_i = 1'b1;
        chk("rst_fe_ready", 64'(fe_ready_o), 64'd1);
        chk("rst_issue_v",  64'(issue_v_o),  64'd0);
        chk("rst_fe_nop",   64'(fe_nop_v_o), 64'd1);
        chk("rst_issue_pc", 64'(issue_pc_o), 64'd0);
        idle();

        // Fill to full; 9th entry dropped
        for (int i = 0; i < ELS; i++)
            step(1'b1, VW'(32'h1000 + 4*i), IW'(32'h13 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 64'(fe_ready_o), 64'd0);
        step(1'b1, VW'(32'hdead), IW'(32'hbad), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 64'(q.size()), 64'(ELS));
        for (int i = 0; i < ELS; i++) begin
            chk("drain_pc", 64'(issue_pc_o), 64'(32'h1000 + 4*i));
            step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_ready", 64'(fe_ready_o), 64'd1);

        // Streaming: enqueue/issue/commit every cycle, 1-cycle latency
        step(1'b1, VW'(32'h2000), IW'(32'h100), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            chk("stream_pc", 64'(issue_pc_o), 64'(32'h2000 + 4*(i-1)));
            step(1'b1, VW'(32'h2000 + 4*i), IW'(32'h100 + i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stream_empty", 64'(issue_v_o), 64'd0);

        // Rollback with same-cycle commit: replay starts at C
        for (int i = 0; i < 4; i++)
            step(1'b1, VW'(32'h3000 + 4*i), IW'(32'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("roll_pc_c", 64'(issue_pc_o), 64'(32'h3008));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("roll_pc_d", 64'(issue_pc_o), 64'(32'h300C));
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Flush with simultaneous enqueue/yumi/commit
        step(1'b1, VW'(32'h4000), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, VW'(32'h4100 + 4*i), IW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, VW'(32'h4200), IW'(32'h55), 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_issue_v", 64'(issue_v_o),  64'd0);
        chk("flush_ready",   64'(fe_ready_o), 64'd1);
        idle();

        // Full with commit: no enqueue that cycle, ready next cycle
        for (int i = 0; i < ELS; i++)
            step(1'b1, VW'(32'h5000 + 4*i), IW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, VW'(32'h5fff), IW'(32'h77), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fullc_ready", 64'(fe_ready_o), 64'd1);
        chk("fullc_occ",   64'(q.size()),   64'(ELS-1));
        step(1'b1, VW'(32'h5ffc), '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic including rollbacks, flushes and mid-run resets
        pc = VW'(32'h8000);
        for (int i = 0; i < 400; i++) begin
            fv  = ($urandom % 4) != 0;
            y   = (issued < q.size()) && ($urandom % 3 != 0);
            c   = (issued > 0 || y) && ($urandom % 2 == 0);
            r   = ($urandom % 16) == 0;
            f   = ($urandom % 40) == 0;
            rst = ($urandom % 80) == 0;
            step(fv, pc, IW'($urandom), y, c, r, f, rst);
            pc += 4;
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
